cpu_thread_switch: RTL and testbench

Per-thread context scheduler for the md5crypt CPU, sitting directly upstream of the per-thread flags store. It picks the next ready thread round-robin and drives `thread_num`, `load_en` and `save_en` so that flags are saved for the outgoing thread and restored for the incoming one. It also tells the instruction pipeline when a thread may issue (`thread_active`). An optional timeslice preempts a thread that runs too long while others wait.

---
 rtl/cpu_thread_switch.sv | 176 +++++++++++++++++
 tb/tb_cpu_thread_switch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cpu_thread_switch.sv
// rtl/cpu_thread_switch.sv - round-robin hardware thread scheduler driving flags store save/restore
//
// Optional feature macro: CPU_TIMESLICE_EN (timeslice counter and forced preemption).
//
// Ports:
//   CLK            clock
//   RST_N          synchronous reset, active low
//   thread_ready   per-thread request for the CPU, sampled only when a thread is picked
//   switch_req     pipeline yield request, honoured only while a thread is running
//   thread_num     thread index to the flags store and register file
//   load_en        restore the context of thread_num
//   save_en        save the context of thread_num
//   thread_active  current thread may issue instructions
//   preempted      one-cycle pulse in SAVE when the switch was forced by the timeslice

module cpu_thread_switch #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
    parameter int TIMESLICE     = 64,
    parameter int TS_MSB        = $clog2(TIMESLICE) - 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_THREADS-1:0]     thread_ready,
    input  logic                     switch_req,
    output logic [N_THREADS_MSB:0]   thread_num,
    output logic                     load_en,
    output logic                     save_en,
    output logic                     thread_active,
    output logic                     preempted
);

    localparam int TW = N_THREADS_MSB + 1;

    if (TIMESLICE < 2 || TS_MSB < 0) begin : g_bad_timeslice
        $error("cpu_thread_switch: TIMESLICE must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_SAVE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   thread_num_q, thread_num_d;
    logic [TW-1:0]   rr_start_q, rr_start_d;

    // Round-robin search: the lowest offset from rr_start wins. Because
    // rr_start is always one past the last pick, the outgoing thread is
    // naturally the last candidate when picking from SAVE.
    logic            pick_vld;
    logic [TW-1:0]   pick_idx;
    logic [TW-1:0]   rr_next;

    always_comb begin
        int unsigned j;
        logic [TW-1:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        cand     = '0;
        for (int i = N_THREADS - 1; i >= 0; i--) begin
            j    = (int'(rr_start_q) + i) % N_THREADS;
            cand = TW'(j);
            if (thread_ready[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        rr_next = (pick_idx == TW'(N_THREADS - 1)) ? '0 : pick_idx + 1'b1;
    end

`ifdef CPU_TIMESLICE_EN
    localparam logic [TS_MSB:0] TS_MAX = (TS_MSB + 1)'(TIMESLICE - 1);

    logic [TS_MSB:0]     cnt_q, cnt_d;
    logic                preempt_q, preempt_d;
    logic [N_THREADS-1:0] cur_oh;
    logic                expire;

    always_comb begin
        cur_oh               = '0;
        cur_oh[thread_num_q] = 1'b1;
        expire = (cnt_q == TS_MAX) && ((thread_ready & ~cur_oh) != '0);
    end
`endif

    always_comb begin
        state_d      = state_q;
        thread_num_d = thread_num_q;
        rr_start_d   = rr_start_q;
`ifdef CPU_TIMESLICE_EN
        cnt_d        = cnt_q;
        preempt_d    = preempt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    thread_num_d = pick_idx;
                    rr_start_d   = rr_next;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef CPU_TIMESLICE_EN
                cnt_d = '0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
`ifdef CPU_TIMESLICE_EN
                // Saturate so a lone thread can run forever without wrapping.
                if (cnt_q != TS_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (switch_req) begin
                    preempt_d = 1'b0;
                    state_d   = S_SAVE;
                end else if (expire) begin
                    preempt_d = 1'b1;
                    state_d   = S_SAVE;
                end
`else
                if (switch_req) begin
                    state_d = S_SAVE;
                end
`endif
            end
            S_SAVE: begin
                if (pick_vld) begin
                    thread_num_d = pick_idx;
                    rr_start_d   = rr_next;
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            thread_num_q <= '0;
            rr_start_q   <= '0;
`ifdef CPU_TIMESLICE_EN
            cnt_q        <= '0;
            preempt_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            thread_num_q <= thread_num_d;
            rr_start_q   <= rr_start_d;
`ifdef CPU_TIMESLICE_EN
            cnt_q        <= cnt_d;
            preempt_q    <= preempt_d;
`endif
        end
    end

    // IDLE presents an all-zero interface; the held index only matters once a
    // thread is loaded.
    assign thread_num    = (state_q == S_IDLE) ? '0 : thread_num_q;
    assign load_en       = (state_q == S_LOAD);
    assign save_en       = (state_q == S_SAVE);
    assign thread_active = (state_q == S_RUN);
`ifdef CPU_TIMESLICE_EN
    assign preempted     = (state_q == S_SAVE) && preempt_q;
`else
    assign preempted     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_thread_switch.sv
// tb/tb_cpu_thread_switch.sv - self-checking bench for cpu_thread_switch

module tb_cpu_thread_switch;

    logic        CLK;
    logic        RST_N;
    logic [15:0] thread_ready;
    logic        switch_req;
    logic [3:0]  thread_num;
    logic        load_en;
    logic        save_en;
    logic        thread_active;
    logic        preempted;

    cpu_thread_switch #(
        .N_THREADS (16),
        .TIMESLICE (8)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .thread_ready  (thread_ready),
        .switch_req    (switch_req),
        .thread_num    (thread_num),
        .load_en       (load_en),
        .save_en       (save_en),
        .thread_active (thread_active),
        .preempted     (preempted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic [15:0] rdy;
        logic        sw;
        logic [3:0]  tn;
        logic        ld;
        logic        sv;
        logic        act;
        logic        pre;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  sb_q[$];
    string       nm_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic vec_t mk(logic r, logic [15:0] rdy, logic sw, logic [3:0] tn,
                                logic ld, logic sv, logic act, logic pre);
        vec_t v;
        v.rst_n = r; v.rdy = rdy; v.sw = sw; v.tn = tn;
        v.ld = ld; v.sv = sv; v.act = act; v.pre = pre;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // compare against the DUT one time unit after the edge.
    task automatic step(input vec_t v, input string nm);
        logic [7:0] exp_v;
        logic [7:0] got_v;
        string      exp_nm;
        @(negedge CLK);
        RST_N        = v.rst_n;
        thread_ready = v.rdy;
        switch_req   = v.sw;
        sb_q.push_back({v.tn, v.ld, v.sv, v.act, v.pre});
        nm_q.push_back(nm);
        @(posedge CLK);
        #1;
        exp_v  = sb_q.pop_front();
        exp_nm = nm_q.pop_front();
        got_v  = {thread_num, load_en, save_en, thread_active, preempted};
        n_checks++;
        if (got_v === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got tn=%0d ld=%b sv=%b act=%b pre=%b, expected tn=%0d ld=%b sv=%b act=%b pre=%b",
                     exp_nm, got_v[7:4], got_v[3], got_v[2], got_v[1], got_v[0],
                     exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    initial begin
        RST_N        = 1'b0;
        thread_ready = '0;
        switch_req   = 1'b0;

        //               rst rdy       sw  tn ld sv act pre
        tbl.push_back(mk(0, 16'h0000, 0,  0, 0, 0, 0, 0)); // reset -> IDLE
        tbl.push_back(mk(1, 16'h0001, 0,  0, 1, 0, 0, 0)); // pick 0, LOAD
        tbl.push_back(mk(1, 16'h0001, 0,  0, 0, 0, 1, 0)); // RUN, load_en single cycle
        tbl.push_back(mk(1, 16'h0111, 1,  0, 0, 1, 0, 0)); // yield: SAVE 0
        tbl.push_back(mk(1, 16'h0111, 0,  4, 1, 0, 0, 0)); // LOAD 4
        tbl.push_back(mk(1, 16'h0111, 0,  4, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h0111, 1,  4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0111, 0,  8, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0111, 0,  8, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h0111, 1,  8, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0111, 0,  0, 1, 0, 0, 0)); // search wraps to 0
        tbl.push_back(mk(1, 16'h0111, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h8000, 1,  0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h8000, 0, 15, 1, 0, 0, 0)); // pick 15, rr_start wraps to 0
        tbl.push_back(mk(1, 16'h8000, 0, 15, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h8000, 1, 15, 0, 1, 0, 0)); // only ready thread yields
        tbl.push_back(mk(1, 16'h8000, 0, 15, 1, 0, 0, 0)); // reloaded from wrapped start
        tbl.push_back(mk(1, 16'h8000, 0, 15, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 1, 15, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0000, 0,  0, 0, 0, 0, 0)); // nobody ready -> IDLE
        tbl.push_back(mk(1, 16'h0001, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0001, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16'h0020, 1,  0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0020, 0,  5, 1, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0020, 0,  5, 0, 0, 1, 0)); // thread 5 running
        tbl.push_back(mk(0, 16'h0020, 0,  0, 0, 0, 0, 0)); // reset mid-RUN: IDLE, no save
        tbl.push_back(mk(1, 16'h0000, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16'h0004, 0,  2, 1, 0, 0, 0)); // rr_start cleared by reset
        tbl.push_back(mk(1, 16'h0000, 0,  2, 0, 0, 1, 0)); // ready drop ignored in RUN
        tbl.push_back(mk(1, 16'h0000, 0,  2, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeslice corner cases.
        step(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0), "ts_reset");
        step(mk(1, 16'h0003, 0, 0, 1, 0, 0, 0), "ts_load0");
`ifdef CPU_TIMESLICE_EN
        for (int k = 0; k < 8; k++)
            step(mk(1, 16'h0003, 0, 0, 0, 0, 1, 0), $sformatf("ts_run0_%0d", k));
        step(mk(1, 16'h0003, 0, 0, 0, 1, 0, 1), "ts_expire_save");
        step(mk(1, 16'h0003, 0, 1, 1, 0, 0, 0), "ts_load1");
        for (int k = 0; k < 8; k++)
            step(mk(1, 16'h0003, 0, 1, 0, 0, 1, 0), $sformatf("ts_run1_%0d", k));
        step(mk(1, 16'h0003, 1, 1, 0, 1, 0, 0), "ts_coincide_save");
        step(mk(1, 16'h0003, 0, 0, 1, 0, 0, 0), "ts_load0b");
        for (int k = 0; k < 24; k++)
            step(mk(1, 16'h0001, 0, 0, 0, 0, 1, 0), $sformatf("ts_solo_%0d", k));
`else
        for (int k = 0; k < 24; k++)
            step(mk(1, 16'h0003, 0, 0, 0, 0, 1, 0), $sformatf("nots_run0_%0d", k));
        step(mk(1, 16'h0003, 1, 0, 0, 1, 0, 0), "nots_yield_save");
        step(mk(1, 16'h0003, 0, 1, 1, 0, 0, 0), "nots_load1");
        for (int k = 0; k < 24; k++)
            step(mk(1, 16'h0001, 0, 1, 0, 0, 1, 0), $sformatf("nots_run1_%0d", k));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
